// File: rtl/music_player_mix.sv
// Play/pause/next control, frame-edge request, tempo-scaled beat and N-voice sample mixer.
// Define MUSIC_PLAYER_SAT_EN to saturate the mix and drive clip; otherwise the sum wraps.
module music_player_mix #(
    parameter int unsigned NUM_VOICES   = 4,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned NUM_SONGS    = 4,
    parameter int unsigned SONG_WIDTH   = 2,
    parameter int unsigned BEAT_COUNT   = 1000,
    parameter int unsigned BEAT_WIDTH   = 10
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               play_button,
    input  logic                               next_button,
    input  logic                               song_done,
    input  logic [1:0]                         tempo_sel,
    input  logic                               new_frame,
    input  logic [NUM_VOICES-1:0]              voice_active,
    input  logic [NUM_VOICES-1:0]              voice_ready,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    output logic                               play,
    output logic                               reset_player,
    output logic [SONG_WIDTH-1:0]              current_song,
    output logic                               generate_next_sample,
    output logic                               beat,
    output logic                               new_sample_generated,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               underrun,
    output logic                               clip
);

    typedef enum logic [1:0] {
        ST_PAUSED   = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_ADV_MAN  = 2'd2,
        ST_ADV_AUTO = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    play_q, play_d;
    logic                    reset_player_q, reset_player_d;
    logic [SONG_WIDTH-1:0]   song_q, song_d;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_PAUSED;
        else          state_q <= state_d;
    end

    // Next state: advance cycles ignore buttons; next beats song_done beats play
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ADV_MAN:  state_d = ST_PAUSED;
            ST_ADV_AUTO: state_d = ST_PLAYING;
            ST_PLAYING: begin
                if (next_button)      state_d = ST_ADV_MAN;
                else if (song_done)   state_d = ST_ADV_AUTO;
                else if (play_button) state_d = ST_PAUSED;
            end
            default: begin
                if (next_button)      state_d = ST_ADV_MAN;
                else if (play_button) state_d = ST_PLAYING;
            end
        endcase
    end

    // Outputs decoded from the next state so they land with the state change
    always_comb begin
        play_d         = (state_d == ST_PLAYING);
        reset_player_d = (state_d == ST_ADV_MAN) || (state_d == ST_ADV_AUTO);
        song_d         = song_q;
        if (reset_player_d) begin
            song_d = (song_q == SONG_WIDTH'(NUM_SONGS - 1)) ? '0 : song_q + SONG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            play_q         <= 1'b0;
            reset_player_q <= 1'b0;
            song_q         <= '0;
        end else begin
            play_q         <= play_d;
            reset_player_q <= reset_player_d;
            song_q         <= song_d;
        end
    end

    // Frame edge detect on the registered strobe
    logic nf_q, nf_prev_q, edge_c;
    logic gns_q;
    assign edge_c = nf_q & ~nf_prev_q;

    // Mixer capture state
    logic [NUM_VOICES-1:0]              flags_q, flags_d;
    logic                               mixed_q, mixed_d;
    logic                               mix_fire_c;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] lat_q, lat_d;
    logic [SAMPLE_WIDTH-1:0]            mix_c;
    logic [SAMPLE_WIDTH-1:0]            pending_q, pending_d;
    logic                               pend_valid_q, pend_valid_d;
    logic [SAMPLE_WIDTH-1:0]            sample_out_q, sample_out_d;
    logic                               nsg_q, underrun_q, underrun_d;

`ifdef MUSIC_PLAYER_SAT_EN
    localparam int unsigned SUM_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        SUM_W'($signed({1'b0, {(SAMPLE_WIDTH-1){1'b1}}}));
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        SUM_W'($signed({1'b1, {(SAMPLE_WIDTH-1){1'b0}}}));
    logic signed [SUM_W-1:0] sum_c;
    logic                    sat_c;
    logic                    clip_q;
`else
    logic signed [SAMPLE_WIDTH-1:0] sum_c;
`endif

    // Capture flags and latches; a ready pulse on the edge cycle belongs to the new frame
    always_comb begin
        flags_d    = (edge_c ? '0 : flags_q) | voice_ready;
        mix_fire_c = (&(flags_d | ~voice_active)) & ~(mixed_q & ~edge_c);
        mixed_d    = (mixed_q & ~edge_c) | mix_fire_c;
        lat_d      = lat_q;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (voice_ready[i]) lat_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    // Signed sum of active voices, reduced to the output width
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (voice_active[i]) begin
`ifdef MUSIC_PLAYER_SAT_EN
                sum_c = sum_c + SUM_W'($signed(lat_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
`else
                sum_c = sum_c + $signed(lat_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
`endif
            end
        end
`ifdef MUSIC_PLAYER_SAT_EN
        sat_c = 1'b0;
        mix_c = sum_c[SAMPLE_WIDTH-1:0];
        if (sum_c > SAT_MAX) begin
            mix_c = SAT_MAX[SAMPLE_WIDTH-1:0];
            sat_c = 1'b1;
        end else if (sum_c < SAT_MIN) begin
            mix_c = SAT_MIN[SAMPLE_WIDTH-1:0];
            sat_c = 1'b1;
        end
`else
        // Low bits of the narrow sum equal the low bits of the wide sum
        mix_c = sum_c;
`endif
    end

    // Pending mix hand-off at frame edges
    always_comb begin
        pend_valid_d = (pend_valid_q & ~edge_c) | mix_fire_c;
        pending_d    = mix_fire_c ? mix_c : pending_q;
        sample_out_d = (edge_c && pend_valid_q) ? pending_q : sample_out_q;
        underrun_d   = edge_c & ~pend_valid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nf_q         <= 1'b0;
            nf_prev_q    <= 1'b0;
            gns_q        <= 1'b0;
            flags_q      <= '0;
            mixed_q      <= 1'b0;
            lat_q        <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            sample_out_q <= '0;
            nsg_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            nf_q         <= new_frame;
            nf_prev_q    <= nf_q;
            gns_q        <= edge_c;
            flags_q      <= flags_d;
            mixed_q      <= mixed_d;
            lat_q        <= lat_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            sample_out_q <= sample_out_d;
            nsg_q        <= mix_fire_c;
            underrun_q   <= underrun_d;
        end
    end

`ifdef MUSIC_PLAYER_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) clip_q <= 1'b0;
        else          clip_q <= mix_fire_c & sat_c;
    end
    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

    // Beat counter: counts frame requests while playing, wraps after the terminal value
    logic [BEAT_WIDTH-1:0] cnt_q, cnt_d, period_c, term_c;
    logic                  beat_q, beat_d;

    always_comb begin
        period_c = BEAT_WIDTH'(BEAT_COUNT >> tempo_sel);
        term_c   = period_c - BEAT_WIDTH'(1);
        cnt_d    = cnt_q;
        beat_d   = 1'b0;
        if (reset_player_q) begin
            cnt_d = '0;
        end else if (gns_q && play_q) begin
            cnt_d  = (cnt_q >= term_c) ? '0 : cnt_q + BEAT_WIDTH'(1);
            beat_d = (cnt_d == term_c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            beat_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign play                 = play_q;
    assign reset_player         = reset_player_q;
    assign current_song         = song_q;
    assign generate_next_sample = gns_q;
    assign beat                 = beat_q;
    assign new_sample_generated = nsg_q;
    assign sample_out           = sample_out_q;
    assign underrun             = underrun_q;

endmodule

// File: tb/tb_music_player_mix.sv
// Directed bench for music_player_mix: control FSM, frame edge, mixer, underrun and beat.
module tb_music_player_mix;
    localparam int unsigned NV  = 4;
    localparam int unsigned SW  = 16;
    localparam int unsigned NS  = 4;
    localparam int unsigned SGW = 2;
    localparam int unsigned BC  = 100;
    localparam int unsigned BW  = 7;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            play_button, next_button, song_done;
    logic [1:0]      tempo_sel;
    logic            new_frame;
    logic [NV-1:0]   voice_active, voice_ready;
    logic [NV*SW-1:0] voice_samples;
    logic            play, reset_player, generate_next_sample, beat;
    logic            new_sample_generated, underrun, clip;
    logic [SGW-1:0]  current_song;
    logic [SW-1:0]   sample_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    music_player_mix #(
        .NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .NUM_SONGS(NS),
        .SONG_WIDTH(SGW), .BEAT_COUNT(BC), .BEAT_WIDTH(BW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .play_button(play_button), .next_button(next_button), .song_done(song_done),
        .tempo_sel(tempo_sel), .new_frame(new_frame),
        .voice_active(voice_active), .voice_ready(voice_ready), .voice_samples(voice_samples),
        .play(play), .reset_player(reset_player), .current_song(current_song),
        .generate_next_sample(generate_next_sample), .beat(beat),
        .new_sample_generated(new_sample_generated), .sample_out(sample_out),
        .underrun(underrun), .clip(clip)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame request; counts beat pulses seen through the beat it may cause
    task automatic frame(output int b);
        b = 0;
        new_frame = 1'b1;
        tick();
        if (beat) b++;
        new_frame = 1'b0;
        tick();
        if (beat) b++;
        tick();
        if (beat) b++;
    endtask

    task automatic press_play();
        play_button = 1'b1;
        tick();
        play_button = 1'b0;
    endtask

    initial begin
        int b, tot, cnt;
        logic [SW-1:0] exp_mix;
        logic          exp_clip;
`ifdef MUSIC_PLAYER_SAT_EN
        exp_mix  = 16'h7FFF;
        exp_clip = 1'b1;
`else
        exp_mix  = 16'h9000;
        exp_clip = 1'b0;
`endif
        reset_n = 1'b0;
        play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
        tempo_sel = 2'd0; new_frame = 1'b0;
        voice_active = '0; voice_ready = '0; voice_samples = '0;
        tick(); tick();
        chk("rst_play", play, 0);
        chk("rst_reset_player", reset_player, 0);
        chk("rst_song", current_song, 0);
        chk("rst_gns", generate_next_sample, 0);
        chk("rst_beat", beat, 0);
        chk("rst_nsg", new_sample_generated, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_clip", clip, 0);
        reset_n = 1'b1;
        tick();

        press_play();
        chk("play_on", play, 1);
        chk("play_no_rp", reset_player, 0);
        next_button = 1'b1;
        tick();
        next_button = 1'b0;
        chk("next_rp", reset_player, 1);
        chk("next_song", current_song, 1);
        chk("next_play_off", play, 0);
        press_play();
        chk("adv_ignores_play", play, 0);
        chk("rp_one_cycle", reset_player, 0);
        tick();
        chk("still_paused", play, 0);
        for (int i = 0; i < 3; i++) begin
            next_button = 1'b1;
            tick();
            next_button = 1'b0;
            tick();
            chk("song_step", current_song, 32'((i + 2) % 4));
        end

        press_play();
        chk("play_again", play, 1);
        song_done = 1'b1; next_button = 1'b1;
        tick();
        song_done = 1'b0; next_button = 1'b0;
        chk("both_rp", reset_player, 1);
        chk("both_song", current_song, 1);
        tick();
        chk("both_paused", play, 0);
        chk("both_single_rp", reset_player, 0);
        chk("both_single_song", current_song, 1);

        press_play();
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        chk("auto_rp", reset_player, 1);
        chk("auto_song", current_song, 2);
        chk("auto_play_low", play, 0);
        tick();
        chk("auto_resumes", play, 1);
        press_play();
        chk("pause", play, 0);

        // Held frame strobe gives one request; a later edge gives another
        tick(); tick();
        cnt = 0;
        new_frame = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (generate_next_sample) cnt++; end
        new_frame = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (generate_next_sample) cnt++; end
        chk("gns_held_level", cnt, 1);
        chk("idle_sample_out", sample_out, 0);
        for (int i = 0; i < 10; i++) tick();
        cnt = 0;
        new_frame = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(); if (generate_next_sample) cnt++; end
        new_frame = 1'b0;
        tick(); tick();
        chk("gns_second_edge", cnt, 1);

        // Mix of two active voices with overwrite of voice 0
        voice_active = 4'b0011;
        new_frame = 1'b1;
        tick(); tick();
        chk("stale_no_underrun", underrun, 0);
        new_frame = 1'b0;
        tick();
        voice_samples[0*SW +: SW] = 16'h1000;
        voice_ready = 4'b0001;
        tick();
        voice_ready = 4'b0000;
        chk("nsg_partial", new_sample_generated, 0);
        voice_samples[0*SW +: SW] = 16'h7000;
        voice_samples[1*SW +: SW] = 16'h2000;
        voice_ready = 4'b0011;
        tick();
        voice_ready = 4'b0000;
        chk("nsg_complete", new_sample_generated, 1);
        chk("clip_mix", clip, 32'(exp_clip));
        tick();
        chk("nsg_once", new_sample_generated, 0);
        chk("held_until_edge", sample_out, 0);
        new_frame = 1'b1;
        tick();
        chk("before_edge_out", sample_out, 0);
        tick();
        chk("mix_out", sample_out, 32'(exp_mix));
        chk("mix_gns", generate_next_sample, 1);
        chk("mix_no_underrun", underrun, 0);
        new_frame = 1'b0;
        tick();

        // Only one of two voices ready: underrun, output held, partial dropped
        voice_samples[0*SW +: SW] = 16'h0100;
        voice_ready = 4'b0001;
        tick();
        voice_ready = 4'b0000;
        chk("ur_nsg", new_sample_generated, 0);
        new_frame = 1'b1;
        tick(); tick();
        chk("underrun_pulse", underrun, 1);
        chk("underrun_hold", sample_out, 32'(exp_mix));
        new_frame = 1'b0;
        tick();
        chk("underrun_one_cycle", underrun, 0);
        voice_samples[1*SW +: SW] = 16'h0300;
        voice_ready = 4'b0010;
        tick();
        voice_ready = 4'b0000;
        chk("partial_discarded", new_sample_generated, 0);
        voice_samples[0*SW +: SW] = 16'h0200;
        voice_ready = 4'b0001;
        tick();
        voice_ready = 4'b0000;
        chk("nsg_small", new_sample_generated, 1);
        chk("clip_small", clip, 0);
        new_frame = 1'b1;
        tick(); tick();
        chk("small_out", sample_out, 32'h0500);
        new_frame = 1'b0;
        tick();

        // Beat: period 100>>1 = 50 frame requests while playing
        voice_active = '0;
        tempo_sel = 2'd1;
        press_play();
        chk("beat_play", play, 1);
        tot = 0;
        for (int i = 0; i < 48; i++) begin frame(b); tot += b; end
        chk("beat_early", tot, 0);
        frame(b);
        chk("beat_first", b, 1);
        tot = 0;
        for (int i = 0; i < 20; i++) begin frame(b); tot += b; end
        chk("beat_mid", tot, 0);
        press_play();
        chk("beat_pause", play, 0);
        tot = 0;
        for (int i = 0; i < 30; i++) begin frame(b); tot += b; end
        chk("beat_paused", tot, 0);
        press_play();
        tot = 0;
        for (int i = 0; i < 29; i++) begin frame(b); tot += b; end
        chk("beat_resume_early", tot, 0);
        frame(b);
        chk("beat_resume", b, 1);
        // Counter at 49 exceeds the new terminal 24: wraps, then 25 requests per beat
        tempo_sel = 2'd2;
        tot = 0;
        for (int i = 0; i < 24; i++) begin frame(b); tot += b; end
        chk("tempo_early", tot, 0);
        frame(b);
        chk("tempo_beat", b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
